// File: rtl/pc_fetch_unit.sv
// Fetch PC generator: holds the PC, issues instruction requests,
// and steers the PC on exception / eret / branch redirects.
module pc_fetch_unit #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = 32'hBFC00000,
    parameter logic [ADDR_W-1:0] EXC_VEC   = 32'hBFC00380,
    parameter int                INC       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              exc_i,
    input  logic              eret_i,
    input  logic [ADDR_W-1:0] epc_i,
    input  logic              br_i,
    input  logic [ADDR_W-1:0] br_target_i,
    input  logic              inst_addr_ok,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    output logic [ADDR_W-1:0] pc_o,
    output logic              adel_o
);

    // S_WAIT: a request is out and must stay up, address frozen, until accepted.
    // A stalled S_RUN is the hold condition: no request raised.
    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] INC_V = ADDR_W'(INC);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [1:0]        pend_pri_q, pend_pri_d;
    logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
    logic [1:0]        live_pri;
    logic [ADDR_W-1:0] live_tgt;
    logic              accept;
    logic              adv;
    logic              take_live;

    // Priority encoding: exc=3, eret=2, branch=1, none=0.
    always_comb begin
        live_pri = 2'd0;
        live_tgt = pc_q;
        priority case (1'b1)
            exc_i: begin
                live_pri = 2'd3;
                live_tgt = EXC_VEC;
            end
            eret_i: begin
                live_pri = 2'd2;
                live_tgt = epc_i;
            end
            br_i: begin
                live_pri = 2'd1;
                live_tgt = br_target_i;
            end
            default: ;
        endcase
    end

    assign accept    = inst_req & inst_addr_ok;
    assign adv       = accept | ~inst_req;
    assign take_live = (live_pri != 2'd0) && (live_pri >= pend_pri_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_RUN;
            pc_q       <= RESET_VEC;
            pend_pri_q <= 2'd0;
            pend_tgt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_pri_q <= pend_pri_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_pri_d = pend_pri_q;
        pend_tgt_d = pend_tgt_q;
        if (adv) begin
            pend_pri_d = 2'd0;
            if (take_live) begin
                pc_d = live_tgt;
            end else if (pend_pri_q != 2'd0) begin
                pc_d = pend_tgt_q;
            end else if (accept) begin
                pc_d = pc_q + INC_V;
            end
            state_d = (pc_d[1:0] != 2'b00) ? S_ERR : S_RUN;
        end else begin
            // Request still outstanding: remember the strongest redirect.
            state_d = S_WAIT;
            if (take_live) begin
                pend_pri_d = live_pri;
                pend_tgt_d = live_tgt;
            end
        end
    end

    always_comb begin
        inst_req = 1'b0;
        adel_o   = 1'b0;
        if (!rst) begin
            unique case (state_q)
                S_RUN:   inst_req = ~stall_i;
                S_WAIT:  inst_req = 1'b1;
                S_ERR:   adel_o   = 1'b1;
                default: ;
            endcase
        end
    end

    assign pc_o      = pc_q;
    assign inst_addr = pc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed and random checks of pc_fetch_unit against a
// redirect-history reference model.
module tb_pc_fetch_unit;

    localparam logic [31:0] RVEC = 32'hBFC00000;
    localparam logic [31:0] EVEC = 32'hBFC00380;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        exc_i = 1'b0;
    logic        eret_i = 1'b0;
    logic [31:0] epc_i = '0;
    logic        br_i = 1'b0;
    logic [31:0] br_target_i = '0;
    logic        inst_addr_ok = 1'b0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] pc_o;
    logic        adel_o;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          pri;
        logic [31:0] tgt;
    } redir_t;

    // Model: PC, outstanding-request flag, misalign flag and every
    // redirect seen since the last advance point.
    logic [31:0] m_pc;
    logic        m_out;
    logic        m_err;
    redir_t      hist[$];

    pc_fetch_unit dut (
        .clk(clk),
        .rst(rst),
        .stall_i(stall_i),
        .exc_i(exc_i),
        .eret_i(eret_i),
        .epc_i(epc_i),
        .br_i(br_i),
        .br_target_i(br_target_i),
        .inst_addr_ok(inst_addr_ok),
        .inst_req(inst_req),
        .inst_addr(inst_addr),
        .pc_o(pc_o),
        .adel_o(adel_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic m_req();
        return !m_err && (m_out || !stall_i);
    endfunction

    task automatic m_reset();
        m_pc  = RVEC;
        m_out = 1'b0;
        m_err = 1'b0;
        hist.delete();
    endtask

    // Applied with the inputs as they were at the clock edge.
    task automatic m_edge();
        logic req, acc;
        int   best;
        req = m_req();
        acc = req && inst_addr_ok;
        if (exc_i) hist.push_back('{3, EVEC});
        else if (eret_i) hist.push_back('{2, epc_i});
        else if (br_i) hist.push_back('{1, br_target_i});
        if (acc || !req) begin
            best = -1;
            foreach (hist[i])
                if (best < 0 || hist[i].pri >= hist[best].pri) best = i;
            if (best >= 0) m_pc = hist[best].tgt;
            else if (acc) m_pc = m_pc + 32'd4;
            hist.delete();
            m_out = 1'b0;
            m_err = (m_pc[1:0] != 2'b00);
        end else begin
            m_out = 1'b1;
        end
    endtask

    task automatic cyc(input logic s, input logic e, input logic r,
                       input logic [31:0] ep, input logic b,
                       input logic [31:0] bt, input logic ok);
        stall_i      = s;
        exc_i        = e;
        eret_i       = r;
        epc_i        = ep;
        br_i         = b;
        br_target_i  = bt;
        inst_addr_ok = ok;
        @(negedge clk);
        chk("inst_req", 32'(inst_req), 32'(m_req()));
        chk("inst_addr", inst_addr, m_pc);
        chk("pc_o", pc_o, m_pc);
        chk("adel_o", 32'(adel_o), 32'(m_err));
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(inst_req), 32'd0);
        chk("rst_pc", pc_o, RVEC);
        chk("rst_adel", 32'(adel_o), 32'd0);
        rst = 1'b0;
        m_reset();
    endtask

    initial begin
        logic [31:0] t;
        m_reset();
        do_reset();

        // Back-to-back fetch from the reset vector.
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 1);
        chk("t1_pc", pc_o, RVEC + 32'd12);

        // Address frozen while waiting; branch latched then taken.
        do_reset();
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 32'h1000, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("t2_hold", inst_addr, RVEC);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("t2_pc", pc_o, 32'h1000);

        // Exception during a stall.
        cyc(0, 0, 0, 0, 1, 32'h2000, 1);
        cyc(1, 1, 0, 0, 0, 0, 1);
        chk("t3_pc", pc_o, EVEC);
        cyc(1, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("t3_next", pc_o, EVEC + 32'd4);

        // Misaligned branch target, recovery by exception.
        cyc(0, 0, 0, 0, 1, 32'h3002, 1);
        chk("t4_adel", 32'(adel_o), 32'd1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 0, 1);
        chk("t4_pc", pc_o, EVEC);
        chk("t4_adel0", 32'(adel_o), 32'd0);
        cyc(0, 0, 0, 0, 0, 0, 1);

        // All three redirects together.
        cyc(0, 1, 1, 32'h4000, 1, 32'h5000, 1);
        chk("t5_pc", pc_o, EVEC);
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 1);
        chk("t5_seq", pc_o, EVEC + 32'd12);

        // Pending branch overridden by a later eret.
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 32'h6000, 0);
        cyc(0, 0, 1, 32'h7000, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 32'h8000, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("t6_pc", pc_o, 32'h7000);

        // Wrap at the top of the address space.
        cyc(0, 0, 0, 0, 1, 32'hFFFFFFFC, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("wrap_pc", pc_o, 32'h0);

        // Asynchronous reset while a request waits.
        stall_i = 1'b0;
        inst_addr_ok = 1'b0;
        @(negedge clk);
        chk("mid_req_hi", 32'(inst_req), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_req_lo", 32'(inst_req), 32'd0);
        chk("mid_pc", pc_o, RVEC);
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Random traffic.
        for (int n = 0; n < 500; n++) begin
            logic s, e, r, b, ok;
            logic [31:0] ep, bt;
            s  = ($urandom_range(0, 3) == 0);
            ok = ($urandom_range(0, 9) < 6);
            e  = ($urandom_range(0, 29) == 0);
            r  = ($urandom_range(0, 19) == 0);
            b  = ($urandom_range(0, 11) == 0);
            t  = $urandom;
            ep = ($urandom_range(0, 9) == 0) ? t : {t[31:2], 2'b00};
            t  = $urandom;
            bt = ($urandom_range(0, 9) == 0) ? t : {t[31:2], 2'b00};
            cyc(s, e, r, ep, b, bt, ok);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
